div_ctrl: RTL and testbench

Issue/response controller placed directly upstream of the iterative divider in the scalar execute stage. It accepts RISC-V DIV/DIVU/REM/REMU(W) operations from issue over a valid/ready handshake and holds the operands stable for the whole division. It drives the divider's request/kill interface, selects quotient or remainder when the divider finishes, and presents the tagged result to writeback over a second valid/ready handshake.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_ctrl.sv | 104 ++++++++++
 tb/tb_div_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the divider issue/response controller.
//   op_e      : RISC-V divide op encoding carried on op_i
//   state_e   : controller FSM states
//   TAG_W_DEF : default destination-tag width
//   fast_hit / fast_result : divisor 0/1 shortcut used when DIV_FASTPATH_EN is defined
package div_pkg;
    localparam int TAG_W_DEF = 6;

    typedef enum logic [1:0] {OP_DIV, OP_DIVU, OP_REM, OP_REMU} op_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    // Divisor is 0 or 1 over the operative width (low 32 bits for W ops).
    function automatic logic fast_hit(logic word, logic [63:0] rs2);
        return word ? rs2[31:1] == '0 : rs2[63:1] == '0;
    endfunction

    // Result for a divisor of 0 or 1; W ops use the sign-extended low word.
    function automatic logic [63:0] fast_result(logic rem, logic word, logic [63:0] rs1, logic [63:0] rs2);
        logic [63:0] src;
        logic        zero;
        src  = word ? {{32{rs1[31]}}, rs1[31:0]} : rs1;
        zero = word ? rs2[31:0] == '0 : rs2 == '0;
        return rem ? (zero ? src : '0) : (zero ? '1 : src);
    endfunction
endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: issue/response controller in front of the iterative divider.
// Ports:
//   clk_i, rstn_i (async, active-low), kill_i (flush, aborts in-flight op)
//   issue side     : valid_i, ready_o, op_i, word_i, rs1_i, rs2_i, tag_i
//   divider side   : div_req_o, div_kill_o, div_int_32_o, div_signed_o,
//                    div_dvnd_o, div_dvsr_o, div_stall_i, div_quo_i, div_rmd_i
//   writeback side : valid_o, ready_i, result_o, tag_o
//   status         : busy_o
// Build option: DIV_FASTPATH_EN resolves divisor 0/1 in IDLE without the divider.
module div_ctrl
    import div_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             kill_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic             word_i,
    input  logic [63:0]      rs1_i,
    input  logic [63:0]      rs2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             div_req_o,
    output logic             div_kill_o,
    output logic             div_int_32_o,
    output logic             div_signed_o,
    output logic [63:0]      div_dvnd_o,
    output logic [63:0]      div_dvsr_o,
    input  logic             div_stall_i,
    input  logic [63:0]      div_quo_i,
    input  logic [63:0]      div_rmd_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [63:0]      result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);
    state_e           r_state;
    logic             r_rem;
    logic             r_int_32;
    logic             r_signed;
    logic [63:0]      r_rs1;
    logic [63:0]      r_rs2;
    logic [63:0]      r_result;
    logic [TAG_W-1:0] r_tag;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= S_IDLE;
            r_rem    <= 1'b0;
            r_int_32 <= 1'b0;
            r_signed <= 1'b0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_result <= '0;
            r_tag    <= '0;
        end else if (kill_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (valid_i) begin
                    r_rem    <= op_i[1];
                    r_int_32 <= word_i;
                    r_signed <= ~op_i[0];
                    r_rs1    <= rs1_i;
                    r_rs2    <= rs2_i;
                    r_tag    <= tag_i;
`ifdef DIV_FASTPATH_EN
                    if (fast_hit(word_i, rs2_i)) begin
                        r_result <= fast_result(op_i[1], word_i, rs1_i, rs2_i);
                        r_state  <= S_RESP;
                    end else begin
                        r_state  <= S_ISSUE;
                    end
`else
                    r_state  <= S_ISSUE;
`endif
                end
                S_ISSUE: r_state <= S_WAIT;
                // Stall low in WAIT marks the divider's DONE cycle; results are valid only now.
                S_WAIT: if (!div_stall_i) begin
                    r_result <= r_rem ? div_rmd_i : div_quo_i;
                    r_state  <= S_RESP;
                end
                S_RESP: if (ready_i) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_o      = r_state == S_IDLE;
    assign busy_o       = r_state != S_IDLE;
    assign valid_o      = r_state == S_RESP;
    assign div_req_o    = r_state == S_ISSUE;
    assign div_kill_o   = kill_i;
    assign div_int_32_o = r_int_32;
    assign div_signed_o = r_signed;
    assign div_dvnd_o   = r_rs1;
    assign div_dvsr_o   = r_rs2;
    assign result_o     = r_result;
    assign tag_o        = r_tag;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed scoreboard bench for div_ctrl with a behavioural divider peer.
module tb_div_ctrl;
    import div_pkg::*;

    localparam int TAG_W = 6;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b0;
    logic             kill_i = 1'b0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [1:0]       op_i = '0;
    logic             word_i = 1'b0;
    logic [63:0]      rs1_i = '0;
    logic [63:0]      rs2_i = '0;
    logic [TAG_W-1:0] tag_i = '0;
    logic             div_req_o;
    logic             div_kill_o;
    logic             div_int_32_o;
    logic             div_signed_o;
    logic [63:0]      div_dvnd_o;
    logic [63:0]      div_dvsr_o;
    logic             div_stall_i = 1'b0;
    logic [63:0]      div_quo_i = '0;
    logic [63:0]      div_rmd_i = '0;
    logic             valid_o;
    logic             ready_i = 1'b1;
    logic [63:0]      result_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;

    div_ctrl #(.TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .kill_i(kill_i),
        .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i), .word_i(word_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .tag_i(tag_i),
        .div_req_o(div_req_o), .div_kill_o(div_kill_o),
        .div_int_32_o(div_int_32_o), .div_signed_o(div_signed_o),
        .div_dvnd_o(div_dvnd_o), .div_dvsr_o(div_dvsr_o),
        .div_stall_i(div_stall_i), .div_quo_i(div_quo_i), .div_rmd_i(div_rmd_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] tag;
        int               vcyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   xfers = 0;
    int   exp_x = 0;
    int   nreq = 0;
    int   exp_req = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference divider semantics (RISC-V), used only to feed the DUT like the real divider would.
    function automatic void div_model(input logic sgn, input logic w, input logic [63:0] a0, input logic [63:0] b0,
                                      output logic [63:0] q, output logic [63:0] r);
        logic [63:0] a, b;
        a = w ? (sgn ? {{32{a0[31]}}, a0[31:0]} : {32'b0, a0[31:0]}) : a0;
        b = w ? (sgn ? {{32{b0[31]}}, b0[31:0]} : {32'b0, b0[31:0]}) : b0;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a;
            r = '0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        if (w) begin
            q = {{32{q[31]}}, q[31:0]};
            r = {{32{r[31]}}, r[31:0]};
        end
    endfunction

    // Divider peer: req seen in T+1, OP cycles stall high, DONE cycle stall low with results.
    initial begin
        logic [63:0] q, r;
        int          n;
        bit          abort;
        forever begin
            @(negedge clk_i);
            if (div_req_o && !div_kill_o) begin
                n = div_int_32_o ? 16 : 32;
                abort = 0;
                div_stall_i = 1'b1;
                for (int i = 0; i < n && !abort; i++) begin
                    @(negedge clk_i);
                    abort = div_kill_o;
                end
                if (!abort) begin
                    @(negedge clk_i);
                    abort = div_kill_o;
                end
                div_stall_i = 1'b0;
                if (!abort) begin
                    div_model(div_signed_o, div_int_32_o, div_dvnd_o, div_dvsr_o, q, r);
                    div_quo_i = q;
                    div_rmd_i = r;
                    @(negedge clk_i);
                    div_quo_i = 64'hDEAD_BEEF_DEAD_BEEF;
                    div_rmd_i = 64'hBEEF_DEAD_BEEF_DEAD;
                end
            end
        end
    end

    // Monitor: compares every presented result against the scoreboard head.
    initial begin
        bit prev_v = 0;
        forever begin
            @(negedge clk_i);
            #1;
            if (div_req_o) nreq++;
            if (rstn_i && valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", result_o, 64'hX);
                end else begin
                    if (!prev_v) chk("valid_cycle", 64'(cyc), 64'(sb[0].vcyc));
                    chk("result", result_o, sb[0].res);
                    chk("tag", 64'(tag_o), 64'(sb[0].tag));
                    chk("ready_o_in_resp", 64'(ready_o), 64'd0);
                    if (ready_i) begin
                        void'(sb.pop_front());
                        xfers++;
                    end
                end
            end
            prev_v = valid_o;
        end
    end

    // Caller is positioned at a negedge; the op is accepted in the current cycle when ready_o is high.
    task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input logic [TAG_W-1:0] tg, input logic [63:0] res);
        exp_t e;
        int   lat;
        bit   hit;
        for (int i = 0; i < 200 && !ready_o; i++) @(negedge clk_i);
        chk("ready_before_issue", 64'(ready_o), 64'd1);
        hit = w ? b[31:1] == '0 : b[63:1] == '0;
`ifdef DIV_FASTPATH_EN
        lat = hit ? 1 : (w ? 19 : 35);
`else
        lat = w ? 19 : 35;
        hit = 0;
`endif
        if (!hit) exp_req++;
        op_i = op;
        word_i = w;
        rs1_i = a;
        rs2_i = b;
        tag_i = tg;
        valid_i = 1'b1;
        e.res = res;
        e.tag = tg;
        e.vcyc = cyc + lat;
        sb.push_back(e);
        exp_x++;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && (sb.size() != 0 || busy_o); i++) @(negedge clk_i);
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk_i);
        chk("rst_ready_o", 64'(ready_o), 64'd1);
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_busy_o", 64'(busy_o), 64'd0);
        chk("rst_div_req_o", 64'(div_req_o), 64'd0);
        chk("rst_result_o", result_o, 64'd0);
        chk("rst_tag_o", 64'(tag_o), 64'd0);
        chk("rst_dvnd", div_dvnd_o, 64'd0);
        chk("rst_mode", {62'd0, div_signed_o, div_int_32_o}, 64'd0);
        rstn_i = 1'b1;
        @(negedge clk_i);

        issue(2'(OP_DIV),  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 6'h05, 64'hFFFF_FFFF_FFFF_FFFD); wait_done();
        issue(2'(OP_REM),  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,                 6'h06, 64'hFFFF_FFFF_FFFF_FFFF); wait_done();
        issue(2'(OP_DIVU), 1'b0, 64'h0000_0000_0000_1234, 64'd0,                 6'h07, 64'hFFFF_FFFF_FFFF_FFFF); wait_done();
        issue(2'(OP_DIV),  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'h08, 64'h8000_0000_0000_0000); wait_done();
        issue(2'(OP_REM),  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'h09, 64'h0);                   wait_done();
        issue(2'(OP_REMU), 1'b0, 64'd100,                 64'd7,                 6'h0A, 64'd2);                   wait_done();
        issue(2'(OP_DIV),  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 6'h0B, 64'hFFFF_FFFF_8000_0000); wait_done();
        issue(2'(OP_DIV),  1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd1,                 6'h0C, 64'hFFFF_FFFF_FFFF_FFFB); wait_done();
        issue(2'(OP_REM),  1'b1, 64'h0000_0001_8000_0000, 64'h0000_0001_0000_0000, 6'h0D, 64'hFFFF_FFFF_8000_0000); wait_done();
        issue(2'(OP_DIVU), 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd3,                 6'h0E, 64'd5);                   wait_done();
        issue(2'(OP_DIVU), 1'b0, 64'd100,                 64'h0000_0001_0000_0000, 6'h0F, 64'd0);                   wait_done();

        // Flush a 64-bit op at T+10, then accept a fresh op at T+11.
        op_i = 2'(OP_DIV);
        word_i = 1'b0;
        rs1_i = 64'd100;
        rs2_i = 64'd7;
        tag_i = 6'h11;
        valid_i = 1'b1;
        t = cyc;
        exp_req++;
        @(negedge clk_i);
        valid_i = 1'b0;
        for (int i = 0; i < 20 && cyc < t + 10; i++) @(negedge clk_i);
        kill_i = 1'b1;
        valid_i = 1'b1;
        #1;
        chk("div_kill_o", 64'(div_kill_o), 64'd1);
        chk("busy_before_kill", 64'(busy_o), 64'd1);
        @(negedge clk_i);
        kill_i = 1'b0;
        valid_i = 1'b0;
        chk("idle_after_kill", 64'(busy_o), 64'd0);
        chk("kill_cycle", 64'(cyc), 64'(t + 11));
        chk("div_kill_released", 64'(div_kill_o), 64'd0);
        issue(2'(OP_DIV), 1'b0, 64'd100, 64'd7, 6'h12, 64'd14); wait_done();

        // Hold writeback off for 5 RESP cycles.
        ready_i = 1'b0;
        issue(2'(OP_DIVU), 1'b0, 64'd1000, 64'd10, 6'h3F, 64'd100);
        for (int i = 0; i < 100 && !valid_o; i++) @(negedge clk_i);
        chk("hold_valid_seen", 64'(valid_o), 64'd1);
        repeat (4) @(negedge clk_i);
        chk("hold_still_valid", 64'(valid_o), 64'd1);
        ready_i = 1'b1;
        @(negedge clk_i);
        chk("hold_released", 64'(valid_o), 64'd0);
        wait_done();

        repeat (3) @(negedge clk_i);
        chk("transfers", 64'(xfers), 64'(exp_x));
        chk("req_pulses", 64'(nreq), 64'(exp_req));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
